// File: rtl/mem_responder_if.sv
// Memory bus between the CPU's address/data path and the memory responder.
interface mem_responder_if;
    logic        Req;
    logic [31:0] Adr;
    logic [31:0] WD;
    logic        WE;
    logic [31:0] RD;
    logic        Ready;
    logic        Busy;
    logic        Fault;

    // CPU side: issues requests and consumes responses
    modport master (output Req, Adr, WD, WE, input RD, Ready, Busy, Fault);
    // Memory side: accepts requests and returns responses
    modport slave  (input Req, Adr, WD, WE, output RD, Ready, Busy, Fault);
endinterface

// File: rtl/mem_responder.sv
// Unified word memory with configurable wait states and a Req/Ready handshake.
// Optional misaligned-access faulting is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_responder #(
    parameter int unsigned DEPTH_LOG2  = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] WAIT_INIT =
        (WAIT_CYCLES == 0) ? CNT_W'(0) : CNT_W'(WAIT_CYCLES - 1);
    localparam logic [31:0] FAULT_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [31:0]             lat_adr;
    logic [31:0]             lat_wd;
    logic                    lat_we;
    logic [31:0]             rd_q;
    logic                    ready_q;
    logic                    busy_q;
    logic                    fault_q;
    logic [31:0]             mem [DEPTH];

    logic [31:0]             adr_c;
    logic [31:0]             wd_c;
    logic                    we_c;
    logic [DEPTH_LOG2-1:0]   idx_c;
    logic                    flt_c;
    logic                    go_resp_c;
    logic                    unused_bits_c;

    // Transaction fields: straight from the bus on a zero-wait acceptance, else the latched copy
    always_comb begin
        adr_c     = (state == S_IDLE) ? bus.Adr : lat_adr;
        wd_c      = (state == S_IDLE) ? bus.WD  : lat_wd;
        we_c      = (state == S_IDLE) ? bus.WE  : lat_we;
        idx_c     = adr_c[DEPTH_LOG2+1:2];
`ifdef MEM_ALIGN_CHECK_EN
        flt_c     = (adr_c[1:0] != 2'b00);
`else
        flt_c     = 1'b0;
`endif
        go_resp_c = ((state == S_IDLE) && bus.Req && (WAIT_CYCLES == 0)) ||
                    ((state == S_WAIT) && (cnt == CNT_W'(0)));
        unused_bits_c = ^{adr_c[31:DEPTH_LOG2+2], adr_c[1:0]};
    end

    // Handshake FSM, memory array access and registered response outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            lat_adr <= '0;
            lat_wd  <= '0;
            lat_we  <= 1'b0;
            rd_q    <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            fault_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.Req) begin
                        lat_adr <= bus.Adr;
                        lat_wd  <= bus.WD;
                        lat_we  <= bus.WE;
                        busy_q  <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state <= S_RESP;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= WAIT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == CNT_W'(0)) begin
                        state <= S_RESP;
                    end else begin
                        cnt <= CNT_W'(cnt - CNT_W'(1));
                    end
                end
                S_RESP: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase

            // The edge entering RESP performs the access and captures the response
            if (go_resp_c) begin
                ready_q <= 1'b1;
                if (flt_c) begin
                    rd_q    <= FAULT_DATA;
                    fault_q <= 1'b1;
                end else if (we_c) begin
                    mem[idx_c] <= wd_c;
                    rd_q       <= wd_c;
                end else begin
                    rd_q <= mem[idx_c];
                end
            end
        end
    end

    assign bus.RD    = rd_q;
    assign bus.Ready = ready_q;
    assign bus.Busy  = busy_q;
    assign bus.Fault = fault_q;
endmodule
